alu_pwr_seq: RTL and testbench

Power-gating sequencer that sits directly upstream of the ALU. It generates the ALU's alu_pwr_en, iso_en, save and restore controls. It watches the issue side (req) and the ALU's busy/result_valid to decide when the ALU can be powered down. The issue logic may drive the ALU's start only while alu_ready is high.

---
 rtl/alu_pwr_seq.sv | 99 +++++++++
 tb/tb_alu_pwr_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq.sv
// Power-gating sequencer for the ALU: drives power enable, isolation, retention save/restore and
// alu_ready from a six-state FSM. All outputs are registered from the next state (no input-to-output path).
module alu_pwr_seq #(
  parameter int IDLE_TIMEOUT  = 16,
  parameter int PWR_UP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sleep_req,
  input  logic        alu_busy,
  input  logic        alu_result_valid,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic        save,
  output logic        restore,
  output logic        alu_ready,
  output logic [2:0]  pwr_state,
  output logic [15:0] sleep_count
);

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWRUP   = 3'd4,
    ST_RESTORE = 3'd5
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [3:0] RAMP_LAST = 4'(PWR_UP_CYCLES - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] idle_cnt;
  logic [3:0] ramp_cnt;
  logic       idle;

  assign idle = !req && !alu_busy && !alu_result_valid;

  always_comb begin
    nxt = state;
    case (state)
      ST_ON:      if (idle && (idle_cnt == IDLE_LAST || sleep_req)) nxt = ST_ISO;
      ST_ISO:     nxt = req ? ST_ON : ST_SAVE;
      // Once save has fired the down sequence must complete; a late req is served from OFF.
      ST_SAVE:    nxt = ST_OFF;
      ST_OFF:     if (req) nxt = ST_PWRUP;
      ST_PWRUP:   if (ramp_cnt == RAMP_LAST) nxt = ST_RESTORE;
      ST_RESTORE: nxt = ST_ON;
      default:    nxt = ST_ON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ON;
      idle_cnt    <= 8'd0;
      ramp_cnt    <= 4'd0;
      sleep_count <= 16'd0;
      alu_pwr_en  <= 1'b1;
      iso_en      <= 1'b0;
      save        <= 1'b0;
      restore     <= 1'b0;
      alu_ready   <= 1'b1;
      pwr_state   <= 3'd0;
    end else begin
      state <= nxt;

      if (state == ST_ON && nxt == ST_ON && idle)
        idle_cnt <= idle_cnt + 8'd1;
      else
        idle_cnt <= 8'd0;

      // Held at zero outside PWRUP so it starts from zero on every entry.
      if (state == ST_PWRUP && nxt == ST_PWRUP)
        ramp_cnt <= ramp_cnt + 4'd1;
      else
        ramp_cnt <= 4'd0;

      if (state == ST_SAVE && nxt == ST_OFF && sleep_count != 16'hFFFF)
        sleep_count <= sleep_count + 16'd1;

      alu_pwr_en <= (nxt != ST_OFF);
      iso_en     <= (nxt != ST_ON);
      save       <= (nxt == ST_SAVE);
      restore    <= (nxt == ST_RESTORE);
      alu_ready  <= (nxt == ST_ON);
      pwr_state  <= nxt;
    end
  end

  // Electrical safety invariants of the gated domain.
  assert property (@(posedge clk) disable iff (!rst_n) !alu_pwr_en |-> iso_en);
  assert property (@(posedge clk) disable iff (!rst_n) (save || restore) |-> alu_pwr_en);
  assert property (@(posedge clk) disable iff (!rst_n) alu_ready |-> (alu_pwr_en && !iso_en));

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq with IDLE_TIMEOUT=4, PWR_UP_CYCLES=4; outputs sampled 1ns after each rising edge.
module tb_alu_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        sleep_req;
  logic        alu_busy;
  logic        alu_result_valid;
  logic        alu_pwr_en;
  logic        iso_en;
  logic        save;
  logic        restore;
  logic        alu_ready;
  logic [2:0]  pwr_state;
  logic [15:0] sleep_count;

  int errors = 0;
  int checks = 0;

  alu_pwr_seq #(.IDLE_TIMEOUT(4), .PWR_UP_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .sleep_req        (sleep_req),
    .alu_busy         (alu_busy),
    .alu_result_valid (alu_result_valid),
    .alu_pwr_en       (alu_pwr_en),
    .iso_en           (iso_en),
    .save             (save),
    .restore          (restore),
    .alu_ready        (alu_ready),
    .pwr_state        (pwr_state),
    .sleep_count      (sleep_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output vector check against a state's expected decode.
  task automatic chk_state(input string tag, input int st);
    chk({tag, ".state"},   pwr_state,  st);
    chk({tag, ".pwr_en"},  alu_pwr_en, (st != 3) ? 1 : 0);
    chk({tag, ".iso"},     iso_en,     (st != 0) ? 1 : 0);
    chk({tag, ".save"},    save,       (st == 2) ? 1 : 0);
    chk({tag, ".restore"}, restore,    (st == 5) ? 1 : 0);
    chk({tag, ".ready"},   alu_ready,  (st == 0) ? 1 : 0);
  endtask

  // Caller holds req high in OFF; expects PWRUP for 4 edges, RESTORE, then ON.
  task automatic wake(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_state({tag, ".pwrup"}, 4);
    end
    step();
    chk_state({tag, ".restore"}, 5);
    step();
    chk_state({tag, ".on"}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("iso_covers_off", int'(iso_en | alu_pwr_en), 1);
      if (save || restore) chk("pwr_during_retention", alu_pwr_en, 1);
    end
  end

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    sleep_req = 1'b0;
    alu_busy = 1'b0;
    alu_result_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0);
    chk("reset.sleep_count", sleep_count, 0);
    rst_n = 1'b1;

    // Auto power-down after 4 idle cycles.
    for (int e = 1; e <= 3; e++) begin
      step();
      chk_state("idle_on", 0);
    end
    step(); chk_state("auto_iso", 1);
    step(); chk_state("auto_save", 2);
    step(); chk_state("auto_off", 3);
    chk("auto_off.sleep_count", sleep_count, 1);

    // Wake from OFF.
    req = 1'b1;
    wake("wake1");
    req = 1'b0;

    // Busy blocks power-down even with sleep_req held.
    alu_busy = 1'b1;
    sleep_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_state("busy_hold", 0);
    end
    alu_busy = 1'b0;
    alu_result_valid = 1'b1;
    step(); chk_state("result_cycle", 0);
    alu_result_valid = 1'b0;
    step(); chk_state("sleep_iso", 1);
    step(); chk_state("sleep_save", 2);
    step(); chk_state("sleep_off", 3);
    chk("sleep_off.sleep_count", sleep_count, 2);
    step(); chk_state("off_ignores_sleep", 3);
    step(); chk_state("off_ignores_sleep2", 3);
    sleep_req = 1'b0;
    req = 1'b1;
    wake("wake2");

    // Abort from ISO, then sleep_req deferred behind a pending req.
    req = 1'b0;
    sleep_req = 1'b1;
    step(); chk_state("abort_iso", 1);
    req = 1'b1;
    step(); chk_state("abort_on", 0);
    chk("abort.sleep_count", sleep_count, 2);
    step(); chk_state("req_before_sleep", 0);
    req = 1'b0;
    step(); chk_state("first_idle_iso", 1);

    // req arriving during SAVE cannot abort the down sequence.
    step(); chk_state("save_late", 2);
    req = 1'b1;
    sleep_req = 1'b0;
    step(); chk_state("save_to_off", 3);
    chk("save_req.sleep_count", sleep_count, 3);
    wake("wake3");
    req = 1'b0;

    // req on the terminal idle cycle clears the counter.
    for (int e = 1; e <= 3; e++) begin
      step();
      chk_state("pre_terminal", 0);
    end
    req = 1'b1;
    step(); chk_state("terminal_req", 0);
    req = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk_state("recount", 0);
    end
    step(); chk_state("recount_iso", 1);
    step(); chk_state("recount_save", 2);
    step(); chk_state("recount_off", 3);
    chk("recount.sleep_count", sleep_count, 4);

    // Asynchronous reset in the middle of PWRUP.
    req = 1'b1;
    step(); chk_state("pre_rst_pwrup", 4);
    step(); chk_state("pre_rst_pwrup2", 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0);
    chk("async_rst.sleep_count", sleep_count, 0);
    req = 1'b0;
    step();
    rst_n = 1'b1;
    step(); chk_state("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
